serial_adder_ctrl: RTL

Bit-serial add/subtract controller that sequences a single `fullAdder` cell over WIDTH clock cycles to produce a WIDTH-bit result. It holds the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake. It is the area-minimal arithmetic path for the lab datapath: one gate-level adder cell shared across all bit positions in time rather than replicated in space.

---
 rtl/serial_adder_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one fullAdder cell is reused over WIDTH
// cycles, with operand shift registers, a carry flop and a start/busy/done handshake.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Handshake: start is sampled only in IDLE or DONE; busy marks the WIDTH RUN
// cycles; done pulses for one cycle when sum/carryout/overflow become valid,
// and those outputs hold until the next accepted start or reset.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             c_msb_in_q, c_msb_in_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic cell_s;
  logic cell_cout;

  fullAdder u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0] ^ sub_q),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_sr_d   = res_sr_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    carry_d    = carry_q;
    c_msb_in_d = c_msb_in_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is a + ~b + 1: the carry seed supplies the +1.
          a_sr_d  = a;
          b_sr_d  = b;
          sub_d   = subtract;
          carry_d = subtract;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_sr_d = {cell_s, res_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        cnt_d    = cnt_q + 1'b1;
        // Carry leaving bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CNT_PENULT) begin
          c_msb_in_d = cell_cout;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d      = cnt_q;
          sum_d      = {cell_s, res_sr_q[WIDTH-1:1]};
          carryout_d = cell_cout;
          overflow_d = c_msb_in_q ^ cell_cout;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_sr_q   <= res_sr_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      carry_q    <= carry_d;
      c_msb_in_q <= c_msb_in_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;
endmodule
